// File: rtl/npc_unit.sv
// Fetch PC register and D-stage next-PC resolution for the pipelined MIPS core.
// Handles the full branch/jump set, eret, exception vectoring and fetch-address checking.
module npc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic [31:0] epc,
    input  logic [31:0] ir_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] rs_d,
    input  logic [31:0] rt_d,
    output logic [31:0] pc_f,
    output logic [31:0] link_d,
    output logic        taken_d,
    output logic        bd_d,
    output logic        flush_f,
    output logic        adel_f
);

    localparam logic [5:0]  OP_SPECIAL = 6'b000000;
    localparam logic [5:0]  OP_REGIMM  = 6'b000001;
    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [5:0]  OP_BNE     = 6'b000101;
    localparam logic [5:0]  OP_BLEZ    = 6'b000110;
    localparam logic [5:0]  OP_BGTZ    = 6'b000111;
    localparam logic [5:0]  FN_JR      = 6'b001000;
    localparam logic [5:0]  FN_JALR    = 6'b001001;
    localparam logic [4:0]  RT_BLTZ    = 5'b00000;
    localparam logic [4:0]  RT_BGEZ    = 5'b00001;
    localparam logic [31:0] ERET_WORD  = 32'h4200_0018;

    // Range bounds carried in 33 bits so IM_BASE + 4*IM_WORDS cannot wrap.
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

    logic [31:0] pc_r;
    logic        bd_r;
    logic [5:0]  op_s;
    logic [4:0]  rt_field_s;
    logic [5:0]  func_s;
    logic        is_eret_s;
    logic        branch_s;
    logic        cond_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] target_s;
    logic [31:0] pc_next_s;
    logic        bd_next_s;
    logic [32:0] pc_ext_s;

    assign op_s        = ir_d[31:26];
    assign rt_field_s  = ir_d[20:16];
    assign func_s      = ir_d[5:0];
    assign is_eret_s   = (ir_d == ERET_WORD);
    assign br_target_s = pc_d + 32'd4 + {{14{ir_d[15]}}, ir_d[15:0], 2'b00};
    assign j_target_s  = {pc_d[31:28], ir_d[25:0], 2'b00};

    // Decode D instruction: branch/jump class, redirect condition and target.
    always_comb begin
        branch_s = 1'b0;
        cond_s   = 1'b0;
        target_s = br_target_s;
        case (op_s)
            OP_BEQ: begin
                branch_s = 1'b1;
                cond_s   = (rs_d == rt_d);
            end
            OP_BNE: begin
                branch_s = 1'b1;
                cond_s   = (rs_d != rt_d);
            end
            OP_BLEZ: begin
                branch_s = 1'b1;
                cond_s   = rs_d[31] | (rs_d == 32'd0);
            end
            OP_BGTZ: begin
                branch_s = 1'b1;
                cond_s   = ~rs_d[31] & (rs_d != 32'd0);
            end
            OP_REGIMM: begin
                case (rt_field_s)
                    RT_BLTZ: begin
                        branch_s = 1'b1;
                        cond_s   = rs_d[31];
                    end
                    RT_BGEZ: begin
                        branch_s = 1'b1;
                        cond_s   = ~rs_d[31];
                    end
                    default: begin
                        branch_s = 1'b0;
                        cond_s   = 1'b0;
                    end
                endcase
            end
            OP_J, OP_JAL: begin
                branch_s = 1'b1;
                cond_s   = 1'b1;
                target_s = j_target_s;
            end
            OP_SPECIAL: begin
                if ((func_s == FN_JR) || (func_s == FN_JALR)) begin
                    branch_s = 1'b1;
                    cond_s   = 1'b1;
                    target_s = rs_d;
                end else begin
                    branch_s = 1'b0;
                    cond_s   = 1'b0;
                end
            end
            default: begin
                branch_s = 1'b0;
                cond_s   = 1'b0;
            end
        endcase
    end

    // Next fetch PC and delay-slot flag, exception first, then stall, eret, redirect.
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        bd_next_s = branch_s;
        if (exc_req) begin
            pc_next_s = EXC_VECTOR;
            bd_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s = pc_r;
            bd_next_s = bd_r;
        end else if (is_eret_s) begin
            pc_next_s = epc;
        end else if (cond_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // Architectural fetch PC and delay-slot state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
            bd_r <= 1'b0;
        end else begin
            pc_r <= pc_next_s;
            bd_r <= bd_next_s;
        end
    end

    assign pc_ext_s = {1'b0, pc_r};
    assign pc_f     = pc_r;
    assign bd_d     = bd_r;
    assign taken_d  = cond_s;
    assign link_d   = pc_d + 32'd8;
    assign flush_f  = is_eret_s & ~exc_req;
    assign adel_f   = (pc_r[1:0] != 2'b00) | (pc_ext_s < IM_LO) | (pc_ext_s >= IM_HI);

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Fetch-side PC register plus D-stage next-PC resolution for the pipelined MIPS core.
- Generalises the old combinational next-PC logic in four ways:
  - full branch set: beq, bne, blez, bgtz, bltz, bgez;
  - jalr and eret;
  - exception vectoring;
  - parametrised instruction-memory bounds with fetch-address checking.
- Holds the architectural fetch PC, delay-slot tracking and the flush request for the instruction after eret.

Parameters:
- RESET_PC, 32'h0000_3000, value of pc_f after reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exc_req.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, number of instruction words. Legal range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold F/D: pc_f and bd_d keep their values.
- exc_req  in  1  exception/interrupt taken this cycle.
- epc  in  32  return address from CP0, used by eret.
- ir_d  in  32  instruction in D.
- pc_d  in  32  PC of the instruction in D.
- rs_d  in  32  forwarded GPR[rs].
- rt_d  in  32  forwarded GPR[rt].
- pc_f  out  32  current fetch PC (registered).
- link_d  out  32  pc_d+8, link value for jal/jalr.
- taken_d  out  1  D instruction redirects the PC.
- bd_d  out  1  D instruction sits in a branch delay slot (registered).
- flush_f  out  1  kill the F instruction (eret in D).
- adel_f  out  1  fetch address error on pc_f.

Behaviour:

Reset values:
- reset=1 (async) forces pc_f=RESET_PC and bd_d=0.
- Combinational outputs follow from those values.

Decode (ir_d, fields op[31:26], rt[20:16], func[5:0]):
- beq 000100: taken iff rs==rt.
- bne 000101: taken iff rs!=rt.
- blez 000110: taken iff rs is signed <=0.
- bgtz 000111: taken iff rs is signed >0.
- regimm 000001 with rt=00000 (bltz): taken iff rs[31].
- regimm 000001 with rt=00001 (bgez): taken iff !rs[31].
- j 000010 and jal 000011: always taken.
- op 000000 with func 001000 (jr) or 001001 (jalr): always taken.
- eret = 32'h4200_0018.
- Comparisons are 32-bit signed. Any other encoding is not taken.

Targets:
- Branch: pc_d+4+{{14{imm[15]}},imm,2'b00}, with 32-bit wrap and no overflow flag.
- j/jal: {pc_d[31:28], ir_d[25:0], 2'b00}.
- jr/jalr: rs_d used unmodified. Misalignment is caught at the next fetch via adel_f.

npc selection and control outputs:
- npc = target if taken_d, else pc_f+4. The F instruction is the delay slot and always executes.
- link_d = pc_d+8 for every instruction (consumer decides whether to use it).
- flush_f = 1 iff ir_d is eret and exc_req=0.
- eret has no delay slot.

pc_f update on each rising edge, in priority order:
1. reset.
2. exc_req: pc_f=EXC_VECTOR.
3. stall: hold.
4. eret in D: pc_f=epc.
5. otherwise pc_f=npc.

bd_d update:
- reset or exc_req: 0.
- stall: hold.
- otherwise: 1 iff ir_d is a branch/jump (any opcode above except eret), whether or not it is taken.

adel_f is combinational and asserts iff any of:
- pc_f[1:0] != 0;
- pc_f < IM_BASE;
- pc_f >= IM_BASE+4*IM_WORDS.
Compute the range check in 33 bits so the bound cannot wrap.

Boundary conditions:
- exc_req with stall: exception wins.
- exc_req with eret: exception wins and flush_f=0.
- stall with a taken branch: redirect is deferred and re-evaluated once stall drops, using the then-current rs_d/rt_d.
- pc_f+4 wraps modulo 2^32.
- reset asserted mid-stall or mid-exception: pc_f returns to RESET_PC immediately, without waiting for a clock edge.

Test Plan:
- Reset, then 3 edges with ir_d=NOP and no stall -> pc_f = 3000, 3004, 3008, 300C. bd_d=0 and adel_f=0 throughout.
- ir_d=bne $1,$2,-2 at pc_d=3008, rs_d=5, rt_d=6 -> taken_d=1, next pc_f=3004, bd_d=1. Same with rs_d=rt_d=5 -> pc_f=pc_f+4, bd_d still 1.
- bgez/bltz/blez/bgtz with rs_d = 0, 1, 32'hFFFF_FFFF -> taken respectively {1,1,0}, {0,0,1}, {1,0,1}, {0,1,0}.
- ir_d=jalr at pc_d=3010, rs_d=3102 -> link_d=3018, pc_f=3102, then adel_f=1. jal 26'h0000C40 at pc_d=3010 -> pc_f=3100.
- eret in D with epc=3020 -> flush_f=1, next pc_f=3020, bd_d=0. Assert exc_req and stall in the same cycle -> pc_f=4180, flush_f=0, bd_d=0.
- stall held 3 cycles while D holds beq taken to 3040 -> pc_f unchanged. On release, one edge -> 3040. Assert reset mid-stall -> pc_f=3000 asynchronously.
